factorial_core: RTL and testbench

- Memory-mapped compute slave that sits directly downstream of the system bus.
- Consumes the bus slave-side signals (select, write, address, write data) and returns registered read data to the bus read mux.
- Computes N! for a 64-bit operand N into a 128-bit result (modulo 2^128) using an iterative shift-add multiplier.
- Raises an optional level interrupt on completion.

---
 rtl/factorial_core_pkg.sv | 30 +++
 rtl/factorial_core_multiplier.sv | 62 ++++++
 rtl/factorial_core.sv | 151 +++++++++++++++
 tb/tb_factorial_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/factorial_core_pkg.sv
// Shared constants for the factorial compute slave: widths, register offsets
// (as s_addr[5:3] indices) and FSM state encoding.
package factorial_core_pkg;

    localparam int DATA_W = 64;
    localparam int RES_W  = 128;

    localparam logic [2:0] ADDR_START    = 3'd0;
    localparam logic [2:0] ADDR_CLEAR    = 3'd1;
    localparam logic [2:0] ADDR_DONE     = 3'd2;
    localparam logic [2:0] ADDR_OPERAND  = 3'd3;
    localparam logic [2:0] ADDR_RESULT_H = 3'd4;
    localparam logic [2:0] ADDR_RESULT_L = 3'd5;
    localparam logic [2:0] ADDR_INTR_EN  = 3'd6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_MUL   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_INIT  = ST_INIT,
        S_CHECK = ST_CHECK,
        S_MUL   = ST_MUL,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/factorial_core_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, product
// truncated to A_W bits. done_o marks the final step; product_o is valid with it.
module factorial_core_multiplier #(
    parameter int A_W       = 128,
    parameter int B_W       = 64,
    parameter int MUL_STEPS = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           flush_i,
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic           done_o,
    output logic [A_W-1:0] product_o
);

    localparam int CNT_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic [A_W-1:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [A_W-1:0]   acc_d;

    // acc_d is the accumulator after the current step, so the last step's
    // product can be consumed on the same edge it is formed.
    assign acc_d     = acc_q + (b_q[0] ? a_q : '0);
    assign product_o = acc_d;
    assign done_o    = busy_q && (cnt_q == LAST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (flush_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            a_q    <= a_q << 1;
            b_q    <= b_q >> 1;
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            busy_q <= !done_o;
        end
    end

endmodule

// File: rtl/factorial_core.sv
// Memory-mapped N! engine: bus register file, control FSM and a shift-add
// multiplier producing a 128-bit result modulo 2^128.
module factorial_core #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int MUL_STEPS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              interrupt
);
    import factorial_core_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0] counter_q, counter_d;
    logic              done_q, done_d;
    logic              intr_en_q, intr_en_d;
    logic [DATA_W-1:0] s_dout_q, s_dout_d;
    logic [DATA_W-1:0] rdata;

    logic              mul_start, mul_flush, mul_done;
    logic [RES_W-1:0]  mul_product;

    logic [2:0] reg_sel;
    logic       wr_en, rd_en, start_req, clear_req;
    logic       unused_addr;

    assign reg_sel     = s_addr[5:3];
    assign unused_addr = ^{s_addr[ADDR_W-1:6], s_addr[2:0]};
    assign wr_en       = s_sel && s_wr;
    assign rd_en       = s_sel && !s_wr;
    assign start_req   = wr_en && (reg_sel == ADDR_START) && s_din[0];
    assign clear_req   = wr_en && (reg_sel == ADDR_CLEAR) && s_din[0];

    assign interrupt = done_q && intr_en_q;
    assign s_dout    = s_dout_q;

    factorial_core_multiplier #(
        .A_W       (RES_W),
        .B_W       (DATA_W),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk       (clk),
        .rst       (reset_n),
        .start_i   (mul_start),
        .flush_i   (mul_flush),
        .a_i       (result_q),
        .b_i       (counter_q),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        rdata = '0;
        case (reg_sel)
            ADDR_DONE:     rdata = {{(DATA_W-2){1'b0}}, interrupt, done_q};
            ADDR_OPERAND:  rdata = operand_q;
            ADDR_RESULT_H: rdata = result_q[RES_W-1:DATA_W];
            ADDR_RESULT_L: rdata = result_q[DATA_W-1:0];
            ADDR_INTR_EN:  rdata = {{(DATA_W-1){1'b0}}, intr_en_q};
            default:       rdata = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        result_d  = result_q;
        counter_d = counter_q;
        done_d    = done_q;
        intr_en_d = intr_en_q;
        mul_start = 1'b0;
        mul_flush = 1'b0;
        s_dout_d  = rd_en ? rdata : '0;

        case (state_q)
            S_IDLE: if (start_req) state_d = S_INIT;
            S_INIT: begin
                result_d  = RES_W'(1);
                counter_d = operand_q;
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (counter_q <= DATA_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    mul_start = 1'b1;
                    state_d   = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    result_d  = mul_product;
                    counter_d = counter_q - DATA_W'(1);
                    state_d   = S_CHECK;
                end
            end
            S_DONE: begin
                if (start_req) begin
                    done_d  = 1'b0;
                    state_d = S_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operand is frozen while a computation is in flight.
        if (wr_en && (reg_sel == ADDR_OPERAND) && (state_q == S_IDLE || state_q == S_DONE))
            operand_d = s_din;
        if (wr_en && (reg_sel == ADDR_INTR_EN))
            intr_en_d = s_din[0];

        if (clear_req) begin
            state_d   = S_IDLE;
            result_d  = '0;
            counter_d = '0;
            done_d    = 1'b0;
            mul_start = 1'b0;
            mul_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q   <= S_IDLE;
            operand_q <= '0;
            result_q  <= '0;
            counter_q <= '0;
            done_q    <= 1'b0;
            intr_en_q <= 1'b0;
            s_dout_q  <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            intr_en_q <= intr_en_d;
            s_dout_q  <= s_dout_d;
        end
    end

endmodule

// File: tb/tb_factorial_core.sv
// Self-checking bench for factorial_core: vector table, hand-written corner
// sequences and random operands against a plain-arithmetic factorial model.
module tb_factorial_core;
    import factorial_core_pkg::*;

    localparam int MUL_STEPS = 64;
    localparam int TIMEOUT   = 4000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         s_sel = 1'b0;
    logic         s_wr = 1'b0;
    logic [15:0]  s_addr = '0;
    logic [63:0]  s_din = '0;
    logic [63:0]  s_dout;
    logic         interrupt;

    int errors = 0;
    int checks = 0;

    factorial_core #(
        .ADDR_W    (16),
        .DATA_W    (64),
        .MUL_STEPS (MUL_STEPS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_sel     (s_sel),
        .s_wr      (s_wr),
        .s_addr    (s_addr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  n;
        logic [127:0] res;
        int           lat;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [127:0] model_fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (longint unsigned k = 2; k <= n; k++) r = r * 128'(k);
        return r;
    endfunction

    function automatic int model_lat(input logic [63:0] n);
        return 2 + (MUL_STEPS + 1) * ((n > 1) ? int'(n) - 1 : 0);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_wr(input logic [2:0] idx, input logic [63:0] d);
        s_sel  = 1'b1;
        s_wr   = 1'b1;
        s_addr = {10'($urandom), idx, 3'($urandom)};
        s_din  = d;
        @(posedge clk);
        @(negedge clk);
        s_sel = 1'b0;
        s_wr  = 1'b0;
        s_din = '0;
    endtask

    task automatic bus_rd(input logic [2:0] idx, output logic [63:0] d);
        s_sel  = 1'b1;
        s_wr   = 1'b0;
        s_addr = {10'($urandom), idx, 3'($urandom)};
        @(negedge clk);
        s_sel = 1'b0;
        d = s_dout;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (interrupt !== 1'b1 && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_fact(input logic [63:0] n, output int lat, output logic [127:0] res);
        logic [63:0] h, l;
        bus_wr(ADDR_OPERAND, n);
        bus_wr(ADDR_START, 64'd1);
        wait_done(lat);
        bus_rd(ADDR_RESULT_H, h);
        bus_rd(ADDR_RESULT_L, l);
        res = {h, l};
    endtask

    task automatic read_all_zero(input string tag);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) begin
            bus_rd(3'(i), d);
            check($sformatf("%s_reg%0d", tag, i), 128'(d), 128'd0);
        end
    endtask

    initial begin
        logic [63:0]  d;
        logic [127:0] res;
        int           lat;
        int           extra;
        logic [63:0]  n;

        vecs[0] = '{64'd0,  128'd1, 2};
        vecs[1] = '{64'd1,  128'd1, 2};
        vecs[2] = '{64'd2,  128'd2, 67};
        vecs[3] = '{64'd3,  128'd6, 132};
        vecs[4] = '{64'd5,  128'h78, 262};
        vecs[5] = '{64'd20, {64'h0, 64'h21C3677C82B40000}, 1237};
        vecs[6] = '{64'd21, {64'h2, 64'hC5077D36B8C40000}, 1302};

        repeat (3) @(negedge clk);
        reset_n = 1'b0;

        check("rst_dout", 128'(s_dout), 128'd0);
        check("rst_intr", 128'(interrupt), 128'd0);
        read_all_zero("rst");

        // START with bit0 clear must not launch (operand 0 would finish in 2 cycles)
        bus_wr(ADDR_START, 64'h2);
        repeat (10) @(negedge clk);
        bus_rd(ADDR_DONE, d);
        check("start_bit0_clear", 128'(d), 128'd0);

        bus_wr(ADDR_INTR_EN, 64'd1);
        foreach (vecs[i]) begin
            run_fact(vecs[i].n, lat, res);
            $display("vec N=%0d latency=%0d result=%0h", vecs[i].n, lat, res);
            check($sformatf("vec_lat_N%0d", vecs[i].n), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("vec_res_N%0d", vecs[i].n), res, vecs[i].res);
        end

        // Interrupt follows INTR_EN while done is held
        bus_wr(ADDR_INTR_EN, 64'd0);
        check("intr_masked", 128'(interrupt), 128'd0);
        bus_rd(ADDR_DONE, d);
        check("done_reg_masked", 128'(d), 128'h1);
        bus_wr(ADDR_INTR_EN, 64'd1);
        check("intr_unmasked", 128'(interrupt), 128'd1);
        bus_rd(ADDR_DONE, d);
        check("done_reg_unmasked", 128'(d), 128'h3);

        // Busy protection: OPERAND and START writes during MUL are ignored
        bus_wr(ADDR_OPERAND, 64'd5);
        bus_wr(ADDR_START, 64'd1);
        repeat (100) @(negedge clk);
        bus_wr(ADDR_OPERAND, 64'd9);
        bus_wr(ADDR_START, 64'd1);
        wait_done(lat);
        check("busy_lat", 128'(lat + 102), 128'd262);
        bus_rd(ADDR_RESULT_L, d);
        check("busy_res", 128'(d), 128'h78);
        bus_rd(ADDR_OPERAND, d);
        check("busy_operand", 128'(d), 128'd5);
        $display("busy-protect N=5 latency=%0d", lat + 102);

        // Clear halfway through N=10
        bus_wr(ADDR_OPERAND, 64'd10);
        bus_wr(ADDR_START, 64'd1);
        repeat (290) @(negedge clk);
        bus_wr(ADDR_CLEAR, 64'd1);
        repeat (700) @(negedge clk);
        check("clr_intr", 128'(interrupt), 128'd0);
        bus_rd(ADDR_DONE, d);
        check("clr_done", 128'(d), 128'd0);
        bus_rd(ADDR_RESULT_L, d);
        check("clr_res_l", 128'(d), 128'd0);
        bus_rd(ADDR_RESULT_H, d);
        check("clr_res_h", 128'(d), 128'd0);
        bus_rd(ADDR_INTR_EN, d);
        check("clr_intr_en", 128'(d), 128'd1);
        bus_wr(ADDR_START, 64'd1);
        wait_done(lat);
        check("clr_restart_lat", 128'(lat), 128'd587);
        bus_rd(ADDR_RESULT_L, d);
        check("clr_restart_res", 128'(d), 128'h375F00);
        $display("clear-restart N=10 latency=%0d result=%0h", lat, d);

        // Read timing: one cycle of data, then zero; offset 0x38 reads 0
        bus_rd(ADDR_OPERAND, d);
        check("rd_operand", 128'(d), 128'd10);
        @(negedge clk);
        check("rd_one_cycle", 128'(s_dout), 128'd0);
        bus_wr(3'd7, 64'($urandom) | 64'd1);
        bus_rd(3'd7, d);
        check("rd_off38", 128'(d), 128'd0);

        // Random operands, including values past 34 that wrap modulo 2^128
        for (int i = 0; i < 6; i++) begin
            n = 64'($urandom_range(0, 36));
            run_fact(n, lat, res);
            $display("rand N=%0d latency=%0d result=%0h", n, lat, res);
            check($sformatf("rand%0d_lat", i), 128'(lat), 128'(model_lat(n)));
            check($sformatf("rand%0d_res", i), res, model_fact(n));
        end

        // Async reset while done is asserted
        #3 reset_n = 1'b1;
        #1;
        check("arst_intr", 128'(interrupt), 128'd0);
        check("arst_dout", 128'(s_dout), 128'd0);
        @(negedge clk);
        reset_n = 1'b0;
        read_all_zero("arst");

        // Async reset in the middle of a computation
        bus_wr(ADDR_INTR_EN, 64'd1);
        bus_wr(ADDR_OPERAND, 64'd10);
        bus_wr(ADDR_START, 64'd1);
        repeat (100) @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        read_all_zero("midrst");
        bus_wr(ADDR_INTR_EN, 64'd1);
        extra = 0;
        while (interrupt !== 1'b1 && extra < 700) begin
            @(negedge clk);
            extra++;
        end
        check("midrst_no_done", 128'(interrupt), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
